// File: rtl/pattern_pkg.sv
// Shared encodings for the video test-pattern generator: pattern modes and
// the colour-bar palette as {R,G,B} on/off masks.
package pattern_pkg;

  typedef enum logic [2:0] {
    PAT_GRAD   = 3'd0,
    PAT_CHECK  = 3'd1,
    PAT_BARS   = 3'd2,
    PAT_BORDER = 3'd3,
    PAT_MOVE   = 3'd4,
    PAT_SOLID  = 3'd5
  } pat_mode_e;

  // Element 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][2:0] BAR_MASK = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

endpackage

// File: rtl/frame_anim.sv
// Frame-level state: frame-start detection, frame counter and the moving-bar
// position, which advances once per frame and wraps before leaving the raster.
module frame_anim #(
  parameter int ACTIVE_H = 1920,
  parameter int CNT_W    = 12,
  parameter int BOX_W    = 64,
  parameter int BOX_STEP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] hcnt,
  input  logic [CNT_W-1:0] vcnt,
  input  logic             de,
  output logic             fs,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] box_x
);

  localparam logic [CNT_W:0] BOX_LIM  = (CNT_W+1)'(ACTIVE_H - BOX_W);
  localparam logic [CNT_W:0] BOX_STEP_X = (CNT_W+1)'(BOX_STEP);

  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] box_x_q, box_x_d;
  logic [CNT_W:0]   box_nxt;

  always_comb begin
    fs          = de && (hcnt == '0) && (vcnt == '0);
    box_nxt     = {1'b0, box_x_q} + BOX_STEP_X;
    frame_cnt_d = frame_cnt_q;
    box_x_d     = box_x_q;
    if (fs) begin
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
      box_x_d     = (box_nxt > BOX_LIM) ? '0 : box_nxt[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
      box_x_q     <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      box_x_q     <= box_x_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign box_x     = box_x_q;

endmodule

// File: rtl/test_pattern_gen.sv
// Video test-pattern generator: per-line counters, pattern mux and the
// registered RGB/de outputs. Mode and solid colour latch only at frame start.
module test_pattern_gen
  import pattern_pkg::*;
#(
  parameter int ACTIVE_H   = 1920,
  parameter int ACTIVE_V   = 1080,
  parameter int CNT_W      = 12,
  parameter int COLOR_W    = 8,
  parameter int CHECK_LOG2 = 8,
  parameter int GRAD_SHIFT = 3,
  parameter int BORDER_W   = 2,
  parameter int BOX_W      = 64,
  parameter int BOX_STEP   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           mode,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  input  logic [CNT_W-1:0]     hcnt,
  input  logic [CNT_W-1:0]     vcnt,
  input  logic                 de,
  output logic [COLOR_W-1:0]   r,
  output logic [COLOR_W-1:0]   g,
  output logic [COLOR_W-1:0]   b,
  output logic                 de_out,
  output logic [CNT_W-1:0]     frame_cnt
);

  localparam int PIX_W = 3*COLOR_W;
  localparam int BAR_W = ACTIVE_H / 8;
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);
  localparam logic [CNT_W-1:0] BORD_LO  = CNT_W'(BORDER_W);
  localparam logic [CNT_W-1:0] H_BORD_HI = CNT_W'(ACTIVE_H - BORDER_W);
  localparam logic [CNT_W-1:0] V_BORD_HI = CNT_W'(ACTIVE_V - BORDER_W);
  localparam logic [CNT_W:0]   BOX_W_X  = (CNT_W+1)'(BOX_W);
  localparam logic [PIX_W-1:0] WHITE    = '1;

  logic             fs;
  logic [CNT_W-1:0] box_x;

  frame_anim #(
    .ACTIVE_H (ACTIVE_H),
    .CNT_W    (CNT_W),
    .BOX_W    (BOX_W),
    .BOX_STEP (BOX_STEP)
  ) u_anim (
    .clk       (clk),
    .reset     (reset),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .de        (de),
    .fs        (fs),
    .frame_cnt (frame_cnt),
    .box_x     (box_x)
  );

  logic [2:0]         mode_q, mode_d, mode_cur;
  logic [PIX_W-1:0]   solid_q, solid_d, solid_cur;
  logic [COLOR_W-1:0] ramp_q, ramp_d, ramp_cur;
  logic [CNT_W-1:0]   bar_cnt_q, bar_cnt_d, bar_cnt_cur;
  logic [2:0]         bar_idx_q, bar_idx_d, bar_idx_cur;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic               de_q, de_d;
  logic               line_start, in_border, in_box;
  logic [2:0]         bar_mask;

  always_comb begin
    line_start = (hcnt == '0);
    // The frame-start pixel already shows the newly selected mode and colour.
    mode_cur   = fs ? mode : mode_q;
    solid_cur  = fs ? solid_rgb : solid_q;
    mode_d     = mode_cur;
    solid_d    = solid_cur;

    ramp_cur = line_start ? '0 : ramp_q;
    ramp_d   = ramp_cur + ((de && (&hcnt[GRAD_SHIFT-1:0])) ? COLOR_W'(1) : '0);

    bar_cnt_cur = line_start ? '0 : bar_cnt_q;
    bar_idx_cur = line_start ? '0 : bar_idx_q;
    bar_cnt_d   = bar_cnt_cur;
    bar_idx_d   = bar_idx_cur;
    if (de) begin
      if (bar_cnt_cur == BAR_LAST) begin
        bar_cnt_d = '0;
        if (bar_idx_cur != 3'd7) bar_idx_d = bar_idx_cur + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_cur + CNT_W'(1);
      end
    end
    bar_mask = BAR_MASK[bar_idx_cur];

    in_border = (hcnt < BORD_LO) || (hcnt >= H_BORD_HI) ||
                (vcnt < BORD_LO) || (vcnt >= V_BORD_HI);
    in_box    = ({1'b0, hcnt} >= {1'b0, box_x}) &&
                ({1'b0, hcnt} <  ({1'b0, box_x} + BOX_W_X));

    pix_d = '0;
    case (mode_cur)
      PAT_GRAD: begin
        case (vcnt[9:8])
          2'b00:   pix_d = {ramp_cur, ramp_cur, ramp_cur};
          2'b01:   pix_d[2*COLOR_W +: COLOR_W] = ramp_cur;
          2'b10:   pix_d[COLOR_W +: COLOR_W]   = ramp_cur;
          default: pix_d[0 +: COLOR_W]         = ramp_cur;
        endcase
      end
      PAT_CHECK:  if (hcnt[CHECK_LOG2] == vcnt[CHECK_LOG2]) pix_d = WHITE;
      PAT_BARS:   pix_d = {{COLOR_W{bar_mask[2]}}, {COLOR_W{bar_mask[1]}}, {COLOR_W{bar_mask[0]}}};
      PAT_BORDER: if (in_border) pix_d = WHITE;
      PAT_MOVE:   if (in_box) pix_d = WHITE;
      PAT_SOLID:  pix_d = solid_cur;
      default:    pix_d = '0;
    endcase
    if (!de) pix_d = '0;
    de_d = de;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q    <= '0;
      solid_q   <= '0;
      ramp_q    <= '0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      pix_q     <= '0;
      de_q      <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      solid_q   <= solid_d;
      ramp_q    <= ramp_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      pix_q     <= pix_d;
      de_q      <= de_d;
    end
  end

  assign r      = pix_q[2*COLOR_W +: COLOR_W];
  assign g      = pix_q[COLOR_W +: COLOR_W];
  assign b      = pix_q[0 +: COLOR_W];
  assign de_out = de_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Directed + randomized bench for test_pattern_gen: a full-HD instance and a
// 128x64 instance share stimulus and are checked against a pixel-rule model.
module tb_test_pattern_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  mode;
  logic [23:0] solid_rgb;
  logic [11:0] hcnt, vcnt;
  logic        de;
  logic [7:0]  r_l, g_l, b_l, r_s, g_s, b_s;
  logic        de_out_l, de_out_s;
  logic [11:0] fc_l, fc_s;

  int vectors = 0;
  int miscompares = 0;
  int mode_m, nfs, ramp_m;
  logic [23:0] solid_m;
  string step;

  always #5 clk = ~clk;

  test_pattern_gen u_big (
    .clk(clk), .reset(reset), .mode(mode), .solid_rgb(solid_rgb),
    .hcnt(hcnt), .vcnt(vcnt), .de(de),
    .r(r_l), .g(g_l), .b(b_l), .de_out(de_out_l), .frame_cnt(fc_l)
  );

  test_pattern_gen #(.ACTIVE_H(128), .ACTIVE_V(64)) u_small (
    .clk(clk), .reset(reset), .mode(mode), .solid_rgb(solid_rgb),
    .hcnt(hcnt), .vcnt(vcnt), .de(de),
    .r(r_s), .g(g_s), .b(b_s), .de_out(de_out_s), .frame_cnt(fc_s)
  );

  function automatic logic [23:0] bar_color(input int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Bar position after n frame starts: positions 0,STEP,.. up to ah-64, then back to 0.
  function automatic int box_of(input int n, input int ah);
    return (n % ((ah - 64) / 4 + 1)) * 4;
  endfunction

  function automatic logic [23:0] pix_exp(input int m, input logic [23:0] sol, input int ah,
                                          input int av, input int bx, input int h, input int v,
                                          input bit d, input int rc);
    logic [7:0] rr;
    int idx;
    rr = 8'(rc);
    if (!d) return 24'h0;
    case (m)
      0: begin
        case ((v >> 8) & 3)
          0: return {rr, rr, rr};
          1: return {rr, 16'h0};
          2: return {8'h0, rr, 8'h0};
          default: return {16'h0, rr};
        endcase
      end
      1: return (((h >> 8) & 1) == ((v >> 8) & 1)) ? 24'hFFFFFF : 24'h0;
      2: begin
        idx = h / (ah / 8);
        if (idx > 7) idx = 7;
        return bar_color(idx);
      end
      3: return (h < 2 || h >= ah - 2 || v < 2 || v >= av - 2) ? 24'hFFFFFF : 24'h0;
      4: return (h >= bx && h < bx + 64) ? 24'hFFFFFF : 24'h0;
      5: return sol;
      default: return 24'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s/%s: observed %h expected %h (h=%0d v=%0d)", step, tag, got, exp, hcnt, vcnt);
    end
  endtask

  task automatic model_reset();
    mode_m = 0; solid_m = '0; nfs = 0; ramp_m = 0;
  endtask

  // Apply one pixel, advance one clock, compare both instances.
  task automatic px(input int h, input int v, input bit d);
    bit fs;
    int rc;
    logic [23:0] e_l, e_s;
    hcnt = 12'(h); vcnt = 12'(v); de = d;
    fs = d && h == 0 && v == 0;
    if (fs) begin
      mode_m  = int'(mode);
      solid_m = solid_rgb;
    end
    rc  = (h == 0) ? 0 : ramp_m;
    e_l = pix_exp(mode_m, solid_m, 1920, 1080, box_of(nfs, 1920), h, v, d, rc);
    e_s = pix_exp(mode_m, solid_m, 128, 64, box_of(nfs, 128), h, v, d, rc);
    if (fs) nfs++;
    ramp_m = (rc + ((d && (h % 8) == 7) ? 1 : 0)) % 256;
    @(posedge clk); #1;
    chk("rgb_big",   {8'h0, r_l, g_l, b_l}, {8'h0, e_l});
    chk("rgb_small", {8'h0, r_s, g_s, b_s}, {8'h0, e_s});
    chk("de_big",    32'(de_out_l), 32'(d));
    chk("de_small",  32'(de_out_s), 32'(d));
    chk("fcnt_big",  32'(fc_l), 32'(nfs % 4096));
    chk("fcnt_small", 32'(fc_s), 32'(nfs % 4096));
  endtask

  task automatic chk_zero();
    chk("rst_rgb_big",   {8'h0, r_l, g_l, b_l}, 32'h0);
    chk("rst_rgb_small", {8'h0, r_s, g_s, b_s}, 32'h0);
    chk("rst_de",        {30'h0, de_out_l, de_out_s}, 32'h0);
    chk("rst_fcnt",      {8'h0, fc_l, fc_s}, 32'h0);
  endtask

  initial begin
    int bx, probes[$];
    reset = 1'b1; mode = 3'd3; solid_rgb = 24'hABCDEF;
    hcnt = '0; vcnt = '0; de = 1'b1;
    model_reset();
    step = "reset";
    repeat (3) @(posedge clk);
    #1; chk_zero();
    reset = 1'b0;

    step = "mode0_before_fs";
    for (int h = 0; h < 64; h++) px(h, 300, 1'b1);

    step = "mode0_ramp";
    mode = 3'd0;
    for (int h = 0; h < 2056; h++) px(h, 0, 1'b1);
    for (int h = 0; h < 64; h++) px(h, 256, 1'b1);
    for (int h = 0; h < 64; h++) px(h, 600, (h % 5) != 0);

    step = "mode2_bars";
    mode = 3'd2;
    for (int h = 0; h < 1920; h++) px(h, 0, 1'b1);
    for (int h = 0; h < 1920; h++) px(h, 5, 1'b1);
    px(0, 6, 1'b0);

    step = "mode3_border";
    mode = 3'd3;
    px(0, 0, 1'b1);
    px(0, 500, 1'b1); px(1918, 500, 1'b1); px(500, 1079, 1'b1);
    px(2, 500, 1'b1); px(500, 500, 1'b0); px(1917, 1077, 1'b1);
    for (int i = 0; i < 40; i++)
      px($urandom_range(0, 2047), $urandom_range(1, 1100), ($urandom % 4) != 0);

    step = "mode1_checker";
    mode = 3'd1;
    px(0, 0, 1'b1);
    for (int i = 0; i < 40; i++)
      px($urandom_range(0, 2047), $urandom_range(1, 1100), ($urandom % 4) != 0);

    step = "switch_1_to_5";
    for (int h = 95; h < 100; h++) px(h, 10, 1'b1);
    mode = 3'd5; solid_rgb = 24'h123456;
    for (int h = 100; h < 111; h++) px(h, 10, 1'b1);
    px(0, 0, 1'b1);
    for (int h = 1; h < 6; h++) px(h, 0, 1'b1);

    step = "mode4_moving";
    mode = 3'd4;
    for (int f = 0; f < 40; f++) begin
      px(0, 0, 1'b1);
      probes = {};
      bx = box_of(nfs, 1920);
      probes.push_back(bx); probes.push_back(bx + 63); probes.push_back(bx + 64);
      if (bx > 0) probes.push_back(bx - 1);
      bx = box_of(nfs, 128);
      probes.push_back(bx); probes.push_back(bx + 63); probes.push_back(bx + 64);
      if (bx > 0) probes.push_back(bx - 1);
      probes.push_back(int'($urandom_range(1, 2047)));
      foreach (probes[i]) px(probes[i], 1 + f, 1'b1);
    end

    step = "frame_wrap";
    mode = 3'd6;
    for (int i = 0; i < 4100; i++) px(0, 0, 1'b1);
    px(300, 300, 1'b1);

    step = "random_frames";
    for (int f = 0; f < 14; f++) begin
      mode = 3'($urandom_range(0, 7));
      solid_rgb = 24'($urandom);
      px(0, 0, 1'b1);
      if (mode == 3'd2) begin
        for (int h = 1; h < 300; h++) px(h, 0, 1'b1);
        for (int h = 0; h < 300; h++) px(h, $urandom_range(1, 1079), 1'b1);
      end else begin
        for (int i = 0; i < 30; i++)
          px($urandom_range(1, 2047), $urandom_range(0, 1100), ($urandom % 4) != 0);
      end
    end

    step = "reset_mid_line";
    mode = 3'd3;
    px(0, 0, 1'b1);
    for (int h = 1; h <= 20; h++) px(h, 7, 1'b1);
    reset = 1'b1; hcnt = 12'd21;
    #1; chk_zero();
    @(posedge clk); #1; chk_zero();
    reset = 1'b0;
    model_reset();
    for (int h = 22; h <= 40; h++) px(h, 7, 1'b1);
    px(0, 0, 1'b1);
    for (int h = 1; h <= 10; h++) px(h, 700, 1'b1);
    px(1919, 700, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
